// File: rtl/rx_disparity_checker_pkg.sv
// Shared PCS definitions for 8b/10b running-disparity checking: special sub-block
// patterns, RD encodings, checker FSM states and the per-code-group result payload.
package rx_disparity_checker_pkg;

  localparam int unsigned CG_W = 10;

  localparam logic [5:0] PAT6_POS = 6'b000111;
  localparam logic [5:0] PAT6_NEG = 6'b111000;
  localparam logic [3:0] PAT4_POS = 4'b0011;
  localparam logic [3:0] PAT4_NEG = 4'b1100;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_LOST  = 2'd2
  } state_t;

  typedef struct packed {
    logic rd;
    logic disp_err;
    logic cv_err;
  } cg_eval_t;

  function automatic logic [2:0] count_ones6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + 3'(v[i]);
    return n;
  endfunction

  function automatic logic [2:0] count_ones4(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + 3'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rx_disparity_checker_eval.sv
// Combinational disparity evaluation of one code-group: 6b sub-block first, then the
// 4b sub-block starting from the RD left by the 6b sub-block.
module cg_disparity_eval
  import rx_disparity_checker_pkg::*;
(
  input  logic [CG_W-1:0] code_group,
  input  logic            rd_entry,
  output cg_eval_t        eval_c
);

  logic [5:0] sb6;
  logic [3:0] sb4;
  logic [2:0] ones6;
  logic [2:0] ones4;
  logic       rd_mid;
  logic       err6;
  logic       err4;

  assign sb6   = code_group[9:4];
  assign sb4   = code_group[3:0];
  assign ones6 = count_ones6(sb6);
  assign ones4 = count_ones4(sb4);

  always_comb begin
    rd_mid = rd_entry;
    err6   = 1'b0;
    err4   = 1'b0;
    eval_c = '0;

    if ((ones6 > 3'd3) || (sb6 == PAT6_POS)) begin
      err6   = (rd_entry != RD_NEG);
      rd_mid = RD_POS;
    end else if ((ones6 < 3'd3) || (sb6 == PAT6_NEG)) begin
      err6   = (rd_entry != RD_POS);
      rd_mid = RD_NEG;
    end

    eval_c.rd = rd_mid;
    if ((ones4 > 3'd2) || (sb4 == PAT4_POS)) begin
      err4      = (rd_mid != RD_NEG);
      eval_c.rd = RD_POS;
    end else if ((ones4 < 3'd2) || (sb4 == PAT4_NEG)) begin
      err4      = (rd_mid != RD_POS);
      eval_c.rd = RD_NEG;
    end

    eval_c.disp_err = err6 | err4;
    eval_c.cv_err   = (ones6 < 3'd2) || (ones6 > 3'd4) || (ones4 < 3'd1) || (ones4 > 3'd3);
  end

endmodule

// File: rtl/rx_disparity_checker.sv
// Receive running-disparity checker: tracks RD across code-groups, flags disparity and
// code violations, counts errors and declares RD lost after a run of bad code-groups.
module rx_disparity_checker
  import rx_disparity_checker_pkg::*;
#(
  parameter int unsigned CG_WIDTH   = 10,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned GOOD_RUN   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cg_valid,
  input  logic [CG_WIDTH-1:0] code_group,
  output logic                cg_valid_out,
  output logic [CG_WIDTH-1:0] code_group_out,
  output logic                rd_out,
  output logic                disp_err,
  output logic                cv_err,
  output logic [7:0]          err_count,
  output logic                rd_lost
);

  localparam int unsigned ERR_W  = $clog2(ERR_THRESH + 1);
  localparam int unsigned GOOD_W = $clog2(GOOD_RUN + 1);

  state_t              state_q, state_d;
  logic [ERR_W-1:0]    err_run_q, err_run_d;
  logic [GOOD_W-1:0]   good_run_q, good_run_d;
  logic                cg_valid_d, rd_d, disp_err_d, cv_err_d, rd_lost_d, bad_c;
  logic [CG_WIDTH-1:0] code_group_d;
  logic [7:0]          err_count_d;
  logic                rd_entry_c;
  cg_eval_t            eval_c;

  // Outside TRACK the RD is unknown, so evaluation restarts from RD-.
  assign rd_entry_c = (state_q == ST_TRACK) ? rd_out : RD_NEG;

  cg_disparity_eval u_eval (
    .code_group (code_group),
    .rd_entry   (rd_entry_c),
    .eval_c     (eval_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    err_run_d    = err_run_q;
    good_run_d   = good_run_q;
    err_count_d  = err_count;
    rd_d         = rd_out;
    code_group_d = code_group_out;
    cg_valid_d   = 1'b0;
    disp_err_d   = 1'b0;
    cv_err_d     = 1'b0;
    bad_c        = 1'b0;

    if (cg_valid) begin
      cg_valid_d   = 1'b1;
      code_group_d = code_group;
      rd_d         = eval_c.rd;
      cv_err_d     = eval_c.cv_err;
      disp_err_d   = eval_c.disp_err && (state_q == ST_TRACK);
      bad_c        = disp_err_d | cv_err_d;
      if (bad_c && (err_count != 8'hFF)) err_count_d = err_count + 8'd1;

      case (state_q)
        ST_TRACK: begin
          if (bad_c) begin
            good_run_d = '0;
            if ((err_run_q + ERR_W'(1)) == ERR_W'(ERR_THRESH)) begin
              state_d   = ST_LOST;
              err_run_d = '0;
            end else begin
              err_run_d = err_run_q + ERR_W'(1);
            end
          end else if ((good_run_q + GOOD_W'(1)) == GOOD_W'(GOOD_RUN)) begin
            good_run_d = '0;
            err_run_d  = '0;
          end else begin
            good_run_d = good_run_q + GOOD_W'(1);
          end
        end
        default: state_d = ST_TRACK;
      endcase
    end

    // Raised only once LOST has been held for a cycle; drops with the resyncing result.
    rd_lost_d = (state_q == ST_LOST) && (state_d == ST_LOST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_run_q      <= '0;
      good_run_q     <= '0;
      err_count      <= '0;
      rd_out         <= RD_NEG;
      code_group_out <= '0;
      cg_valid_out   <= 1'b0;
      disp_err       <= 1'b0;
      cv_err         <= 1'b0;
      rd_lost        <= 1'b0;
    end else begin
      err_run_q      <= err_run_d;
      good_run_q     <= good_run_d;
      err_count      <= err_count_d;
      rd_out         <= rd_d;
      code_group_out <= code_group_d;
      cg_valid_out   <= cg_valid_d;
      disp_err       <= disp_err_d;
      cv_err         <= cv_err_d;
      rd_lost        <= rd_lost_d;
    end
  end

endmodule

// File: tb/tb_rx_disparity_checker.sv
// Bench for rx_disparity_checker: directed code-group sequences, a behavioural
// reference checked every cycle, and hand-computed expectations at key points.
module tb_rx_disparity_checker;

  localparam int unsigned ERR_THRESH = 4;
  localparam int unsigned GOOD_RUN   = 4;

  localparam logic [9:0] CG_A = 10'b0011111010;  // 6b needs RD-, gives RD+
  localparam logic [9:0] CG_B = 10'b1100000101;  // 6b needs RD+, gives RD-
  localparam logic [9:0] CG_C = 10'b0000001010;  // 6b all zeros: code violation

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cg_valid = 1'b0;
  logic [9:0] code_group = '0;
  logic       cg_valid_out, rd_out, disp_err, cv_err, rd_lost;
  logic [9:0] code_group_out;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  rx_disparity_checker #(
    .CG_WIDTH   (10),
    .ERR_THRESH (ERR_THRESH),
    .GOOD_RUN   (GOOD_RUN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cg_valid       (cg_valid),
    .code_group     (code_group),
    .cg_valid_out   (cg_valid_out),
    .code_group_out (code_group_out),
    .rd_out         (rd_out),
    .disp_err       (disp_err),
    .cv_err         (cv_err),
    .err_count      (err_count),
    .rd_lost        (rd_lost)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference: one rule applied to either sub-block.
  function automatic void sub_block(input int ones, input int thr, input bit pos_pat,
                                    input bit neg_pat, input bit entry,
                                    output bit exit_rd, output bit err);
    exit_rd = entry;
    err     = 1'b0;
    if (ones > thr || pos_pat) begin
      err = (entry != 1'b0); exit_rd = 1'b1;
    end else if (ones < thr || neg_pat) begin
      err = (entry != 1'b1); exit_rd = 1'b0;
    end
  endfunction

  bit         m_synced, m_in_lost, e_valid, e_rd, e_disp, e_cv, e_lost;
  int         m_err_run, m_good, e_cnt;
  logic [9:0] e_cg;
  bit         t_mid, t_exit, t_e6, t_e4, t_d, t_c, t_was_lost;
  int         t_o6, t_o4;

  always @(posedge clk) begin
    if (reset) begin
      m_synced = 0; m_in_lost = 0; m_err_run = 0; m_good = 0;
      e_valid = 0; e_rd = 0; e_disp = 0; e_cv = 0; e_lost = 0; e_cnt = 0; e_cg = '0;
    end else begin
      t_was_lost = m_in_lost;
      e_valid = cg_valid; e_disp = 0; e_cv = 0;
      if (cg_valid) begin
        t_o6 = $countones(code_group[9:4]);
        t_o4 = $countones(code_group[3:0]);
        sub_block(t_o6, 3, code_group[9:4] == 6'b000111, code_group[9:4] == 6'b111000,
                  m_synced ? e_rd : 1'b0, t_mid, t_e6);
        sub_block(t_o4, 2, code_group[3:0] == 4'b0011, code_group[3:0] == 4'b1100,
                  t_mid, t_exit, t_e4);
        t_d = m_synced && (t_e6 || t_e4);
        t_c = !(t_o6 >= 2 && t_o6 <= 4) || !(t_o4 >= 1 && t_o4 <= 3);
        e_cg = code_group; e_rd = t_exit; e_disp = t_d; e_cv = t_c;
        if ((t_d || t_c) && e_cnt < 255) e_cnt++;
        if (!m_synced) begin
          m_synced = 1; m_in_lost = 0;
        end else if (t_d || t_c) begin
          m_good = 0; m_err_run++;
          if (m_err_run == ERR_THRESH) begin
            m_synced = 0; m_in_lost = 1; m_err_run = 0;
          end
        end else begin
          m_good++;
          if (m_good == GOOD_RUN) begin m_good = 0; m_err_run = 0; end
        end
      end
      e_lost = t_was_lost && m_in_lost;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      cmp("cg_valid_out", 32'(cg_valid_out), 32'(e_valid));
      cmp("code_group_out", 32'(code_group_out), 32'(e_cg));
      cmp("rd_out", 32'(rd_out), 32'(e_rd));
      cmp("disp_err", 32'(disp_err), 32'(e_disp));
      cmp("cv_err", 32'(cv_err), 32'(e_cv));
      cmp("err_count", 32'(err_count), 32'(e_cnt));
      cmp("rd_lost", 32'(rd_lost), 32'(e_lost));
    end
  end

  // Drive at a falling edge; returns at the next falling edge, where its result shows.
  task automatic step(input bit v, input logic [9:0] cg);
    cg_valid   = v;
    code_group = cg;
    @(negedge clk);
  endtask

  logic [9:0] table_cg [8] = '{10'b0001110011, 10'b1110001100, 10'b1010100000,
                               10'b1111111111, 10'b0101011010, 10'b1101000111,
                               10'b0010111000, 10'b1001100101};

  initial begin
    reset = 1; cg_valid = 1; code_group = 10'h3FF;
    @(negedge clk);
    check_en = 1;
    @(negedge clk);
    cmp("lit_reset_valid", 32'(cg_valid_out), 32'd0);
    cmp("lit_reset_cg", 32'(code_group_out), 32'd0);
    cmp("lit_reset_cnt", 32'(err_count), 32'd0);
    reset = 0;

    step(1, CG_A);
    cmp("lit_a_rd", 32'(rd_out), 32'd1);
    cmp("lit_a_err", 32'({disp_err, cv_err}), 32'd0);
    step(1, CG_B);
    cmp("lit_b_rd", 32'(rd_out), 32'd0);
    cmp("lit_b_err", 32'({disp_err, cv_err}), 32'd0);
    cmp("lit_b_cnt", 32'(err_count), 32'd0);

    step(1, CG_A);
    step(1, CG_A);
    cmp("lit_disp_flag", 32'(disp_err), 32'd1);
    cmp("lit_disp_rd", 32'(rd_out), 32'd1);
    cmp("lit_disp_cnt", 32'(err_count), 32'd1);

    step(1, CG_C);
    cmp("lit_cv_flags", 32'({disp_err, cv_err}), 32'b01);
    cmp("lit_cv_cnt", 32'(err_count), 32'd2);
    step(1, CG_C);
    cmp("lit_both_flags", 32'({disp_err, cv_err}), 32'b11);
    cmp("lit_both_cnt", 32'(err_count), 32'd3);
    step(1, CG_C);
    cmp("lit_4th_lost", 32'(rd_lost), 32'd0);
    cmp("lit_4th_cnt", 32'(err_count), 32'd4);
    step(0, '0);
    cmp("lit_lost_high", 32'(rd_lost), 32'd1);
    step(1, CG_B);
    cmp("lit_resync_lost", 32'(rd_lost), 32'd0);
    cmp("lit_resync_disp", 32'(disp_err), 32'd0);
    cmp("lit_resync_rd", 32'(rd_out), 32'd0);

    // Three errors, four clean groups clear the run, three more errors: no loss.
    step(1, CG_A);
    for (int i = 0; i < 3; i++) step(1, CG_A);
    step(1, CG_B); step(1, CG_A); step(1, CG_B); step(1, CG_A);
    for (int i = 0; i < 3; i++) step(1, CG_A);
    step(0, '0);
    step(0, '0);
    cmp("lit_goodrun_lost", 32'(rd_lost), 32'd0);
    cmp("lit_goodrun_cnt", 32'(err_count), 32'd10);

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) begin
        step(1, table_cg[i]);
        if (i % 3 == 2) step(0, '0);
      end

    for (int i = 0; i < 300; i++) step(1, CG_C);
    cmp("lit_sat_cnt", 32'(err_count), 32'd255);

    step(1, CG_A);
    reset = 1;
    step(1, CG_B);
    cmp("lit_mid_reset", 32'({cg_valid_out, code_group_out, rd_out, disp_err, cv_err,
                             err_count, rd_lost}), 32'd0);
    reset = 0;
    step(1, CG_B);
    cmp("lit_post_init_disp", 32'(disp_err), 32'd0);
    cmp("lit_post_init_valid", 32'(cg_valid_out), 32'd1);
    step(1, CG_B);
    cmp("lit_post_track_disp", 32'(disp_err), 32'd1);
    step(0, '0);

    check_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_disparity_checker.md
RX_DISPARITY_CHECKER -- requirements
Module: rx_disparity_checker

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter CG_WIDTH SHALL default to 10 and mean the code-group width; only 10 is supported.
REQ-003 Parameter ERR_THRESH SHALL default to 4 and mean the consecutive-error run that declares RD lost.
REQ-004 Parameter GOOD_RUN SHALL default to 4 and mean the good code-groups needed to clear the error run.
REQ-005 Port clk SHALL be an input, 1 bit, and the rising-edge clock.
REQ-006 Port reset SHALL be an input, 1 bit, and the synchronous active-high reset.
REQ-007 Port cg_valid SHALL be an input, 1 bit, and qualify code_group this cycle.
REQ-008 Port code_group SHALL be an input, CG_WIDTH bits, with the 6b sub-block on [9:4] and the 4b sub-block on [3:0].
REQ-009 Port cg_valid_out SHALL be an output, 1 bit, and qualify all result outputs.
REQ-010 Port code_group_out SHALL be an output, CG_WIDTH bits, carrying the registered copy of code_group.
REQ-011 Port rd_out SHALL be an output, 1 bit, giving the running disparity after the code-group (0=RD-, 1=RD+).
REQ-012 Port disp_err SHALL be an output, 1 bit, and mark a disparity-rule violation.
REQ-013 Port cv_err SHALL be an output, 1 bit, and mark a sub-block whose disparity magnitude is illegal.
REQ-014 Port err_count SHALL be an output, 8 bits, holding the saturating count of disp_err or cv_err events.
REQ-015 Port rd_lost SHALL be an output, 1 bit, and be high while the block is in LOST.

Function
REQ-016 Latency SHALL be one cycle: the result for a code-group accepted on cycle N SHALL appear on cycle N+1 with cg_valid_out=1.
REQ-017 A cycle with cg_valid=0 SHALL give cg_valid_out=0, disp_err=0 and cv_err=0 on the next cycle, and SHALL hold the RD register and counters.
REQ-018 6b check: ones>3 or the pattern 000111 requires an entry RD of RD- and gives RD+. Ones<3 or the pattern 111000 requires an entry RD of RD+ and gives RD-. Any other neutral pattern requires nothing and keeps the entry RD.
REQ-019 4b check: the same rules SHALL apply with threshold 2 and special patterns 0011 (gives RD+) and 1100 (gives RD-). The 4b entry RD SHALL be the RD produced by the 6b sub-block.
REQ-020 disp_err SHALL be 1 if either sub-block's requirement is violated.
REQ-021 cv_err SHALL be 1 if the 6b ones count is not in {2,3,4} or the 4b ones count is not in {1,2,3}.
REQ-022 The RD register SHALL always update from the received bits, even when an error is flagged.
REQ-023 The FSM SHALL have the states INIT, TRACK and LOST.
REQ-024 INIT is the state after reset. On the first valid code-group, INIT SHALL evaluate with an entry RD of RD-, suppress disp_err (cv_err still active), and go to TRACK.
REQ-025 In TRACK, each valid code-group with disp_err or cv_err SHALL increment err_run and clear good_run.
REQ-026 In TRACK, each clean valid code-group SHALL increment good_run. When good_run reaches GOOD_RUN, err_run and good_run SHALL both clear.
REQ-027 When err_run reaches ERR_THRESH, the FSM SHALL go to LOST, with rd_lost=1 starting the next cycle.
REQ-028 LOST SHALL behave as INIT on the next valid code-group and return to TRACK. rd_lost SHALL fall together with that result.
REQ-029 err_count SHALL increment by 1 per erroneous code-group (disp_err and cv_err together count once) and SHALL saturate at 255.
REQ-030 Simultaneous disp_err and cv_err SHALL both be reported.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL take: state=INIT; rd register=0; cg_valid_out, disp_err, cv_err, rd_lost=0; code_group_out=0; err_count=0; err_run=0; good_run=0.
REQ-032 Reset SHALL take priority over cg_valid, and a code-group presented during reset SHALL be discarded.

Structure
REQ-033 Patterns 6'b000111, 6'b111000, 4'b0011 and 4'b1100, the RD encodings (RD_NEG=0, RD_POS=1) and the FSM state encoding SHALL live in the shared pcs package.
REQ-034 The combinational per-code-group evaluation (entry RD in; exit RD, disp_err and cv_err out) SHALL be a sub-module named cg_disparity_eval. The FSM, registers and counters SHALL stay in the top module.

Verification
REQ-035 Reset, then send 0011111010 followed by 1100000101 → both results have disp_err=0 and cv_err=0, rd_out=1 then 0, err_count=0.
REQ-036 In TRACK with RD+, send 0011111010 → disp_err=1, rd_out=1, err_count increments by 1.
REQ-037 Send 0000001010 → cv_err=1, and err_count increments once even if disp_err is also 1.
REQ-038 In TRACK, send ERR_THRESH=4 consecutive erroneous code-groups → rd_lost=1 the cycle after the 4th result. The next valid code-group gives disp_err=0 and rd_lost=0.
REQ-039 Force 300 errors → err_count stays at 255. Assert reset mid-stream → all outputs are zero the next cycle, and the first code-group afterwards is treated as INIT.
